layer_scheduler: RTL
====================

# layer_scheduler

Top-level sequencer for the PL inference pipeline. It launches the network layers in fixed order (CONV1 … FC3), one at a time, on a single `run` request from the PS. It gives the active layer exclusive ownership of the shared activation RAM and the two weight ROM ports. At the end it captures the final FC3 scores into a classification result.

## Interface
Parameters:
- `N_LAYERS`, 7: number of sequenced layers. Index 0 runs first; index `N_LAYERS-1` is FC3.
- `TIMEOUT`, 1048576: maximum number of cycles a layer may stay in WAIT before an error is raised.
- `GAP_CYC`, 2: minimum idle cycles between one layer's end and the next layer's start.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `run`, in, 1: start-inference pulse from the PS. Sampled only in IDLE.
- `abort`, in, 1: synchronous abort. Takes priority over every other event.
- `busy`, out, 1: high from LAUNCH of layer 0 until FINISH/IDLE.
- `done`, out, 1: one-cycle pulse when the final layer completes.
- `err`, out, 1: timeout flag. Sticky until the next accepted `run` or `abort`.
- `cur_layer`, out, 3: index of the active layer.
- `layer_start`, out, `N_LAYERS`: one-hot, one-cycle start pulse per layer.
- `layer_end`, in, `N_LAYERS`: per-layer end level. It may stay high for several cycles.
- `l_ram_addr_w`, `l_ram_data_w`, `l_ram_en`, `l_ram_wea`, `l_ram_addr_r`, `l_ram_en_r`, `l_rom_addr_rw`, `l_rom_en_rw`, `l_rom_addr_row`, `l_rom_en_row`, in, `N_LAYERS`× field width (16/8/1/1/16/1/16/1/9/1): flattened per-layer request buses. Layer k occupies slice [k*W +: W].
- `ram_addr_w` out 16, `ram_data_w` out 8, `ram_en` out 1, `ram_wea` out 1, `ram_addr_r` out 16, `ram_en_r` out 1, `rom_addr_rw` out 16, `rom_en_rw` out 1, `rom_addr_row` out 9, `rom_en_row` out 1: shared memory ports. Read data is broadcast to all layers outside this block.
- `score_a`, `score_b`, in, 8 signed: FC3 output scores (female, male).
- `class_out`, out, 1: 1 = male. `result_valid`, out, 1: high once a result has been captured.

## Operation
States:
- **IDLE**
  - `run`=1 → LAUNCH with idx=0.
  - Accepting `run` clears `err` and `result_valid`.
- **LAUNCH** (1 cycle)
  - `layer_start[idx]`=1.
  - Timeout counter cleared.
  - → WAIT.
- **WAIT**
  - Timeout counter increments every cycle.
  - Rising edge of `layer_end[idx]` (level vs. its registered copy) → GAP, with the gap counter cleared.
  - Counter reaching `TIMEOUT` → ERROR.
- **GAP**
  - Gap counter increments every cycle.
  - Leaves GAP only when `layer_end[idx]`=0 AND gap counter ≥ `GAP_CYC`.
  - If idx = `N_LAYERS-1` → FINISH; otherwise idx+1 → LAUNCH.
- **FINISH** (1 cycle)
  - `done`=1.
  - Captures `class_out` = (signed `score_b` > signed `score_a`). A tie yields 0.
  - `result_valid`=1.
  - → IDLE.
- **ERROR**
  - `err`=1, `busy`=0.
  - Waits for `run` (restarts from idx 0) or `abort` (→ IDLE).

Port ownership:
- The shared ports follow slice `cur_layer` combinationally, only in LAUNCH and WAIT.
- In every other state all enables/wea are 0 and addresses/data are 0.

Boundary cases:
- `run` while busy: ignored.
- `abort` in any state: → IDLE next edge, `busy`=0, all enables 0, `err` cleared. No `done`.
- `layer_end` edges on non-active layers: ignored.
- `layer_end[idx]` already high at LAUNCH: this is not an edge, so no advance. Only a fresh 0→1 transition after LAUNCH counts.
- Reset mid-run: all state lost; outputs return to reset values immediately (asynchronous).

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `layer_start`, `class_out`, `result_valid` = 0; `cur_layer`=0; all shared ports 0.
- `run` high at edge t:
  - LAUNCH at t+1: `layer_start[0]`=1 and `busy`=1 during cycle t+1.
  - WAIT from t+2.
- Edge detect: `layer_end` rising in cycle e is seen at edge e+1 (→ GAP).
- The next `layer_start` occurs ≥ `GAP_CYC`+2 cycles after the end rise. With an end pulse held for 3 cycles and `GAP_CYC`=2, the next start comes 5 cycles after the end rise.
- Scores are sampled at the FINISH edge, so they must be stable once FC3's end rises.
- The memory mux adds no cycles: the layers' 2-cycle read latency is preserved.

## Structure
- Package `sched_pkg`:
  - State enum (IDLE, LAUNCH, WAIT, GAP, FINISH, ERROR).
  - Layer index constants L_CONV1 … L_FC3.
  - Port field widths (16, 8, 9).
  - Default `TIMEOUT` and `GAP_CYC`.
- Sub-module `layer_port_mux`: purely combinational slice select plus gating by an `own` enable. The FSM, counters, edge detect and result capture stay in `layer_scheduler`.

## Test plan
- **Normal run:** `run` pulse, each layer model raises end 20 cycles after its start and holds it 3 cycles → starts 0…6 in order, each exactly one cycle. `done` pulses once. `busy` falls on the cycle after `done`.
- **Scores and tie:** `score_a`=-5, `score_b`=12 → `class_out`=1, `result_valid`=1. Rerun with 30/30 → `class_out`=0.
- **Timeout:** `TIMEOUT`=64, layer 3 never ends → ERROR after 64 WAIT cycles, `err`=1, all enables 0. A following `run` restarts at layer 0 with `err`=0.
- **Abort:** `abort` during layer 2 WAIT → IDLE next cycle, no `done`, and `layer_start[3]` never pulses.
- **Ownership and stale end:** only layer 1 drives `ram_en`; layer 4 asserts `ram_en` and a spurious `layer_end` → shared `ram_en` stays 0 and the sequence is unaffected. A `layer_end[k]` held high through its LAUNCH causes no advance until a fresh rise.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// Shared types and constants for the inference layer sequencer: FSM states,
// layer indices, shared memory port widths and the per-layer request bundle.
package sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FINISH,
        S_ERROR
    } sched_state_t;

    localparam int L_CONV1 = 0;
    localparam int L_CONV2 = 1;
    localparam int L_CONV3 = 2;
    localparam int L_CONV4 = 3;
    localparam int L_FC1   = 4;
    localparam int L_FC2   = 5;
    localparam int L_FC3   = 6;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int ROW_W  = 9;

    localparam int DEF_TIMEOUT = 1048576;
    localparam int DEF_GAP_CYC = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] ram_addr_w;
        logic [DATA_W-1:0] ram_data_w;
        logic              ram_en;
        logic              ram_wea;
        logic [ADDR_W-1:0] ram_addr_r;
        logic              ram_en_r;
        logic [ADDR_W-1:0] rom_addr_rw;
        logic              rom_en_rw;
        logic [ROW_W-1:0]  rom_addr_row;
        logic              rom_en_row;
    } mem_req_t;

endpackage

// File: rtl/layer_port_mux.sv
// Combinational selector handing the shared RAM/ROM ports to one layer; when
// ownership is not granted every field is forced to zero.
module layer_port_mux
    import sched_pkg::*;
#(
    parameter int N_LAYERS = 7
) (
    input  logic [N_LAYERS*ADDR_W-1:0] l_ram_addr_w,
    input  logic [N_LAYERS*DATA_W-1:0] l_ram_data_w,
    input  logic [N_LAYERS-1:0]        l_ram_en,
    input  logic [N_LAYERS-1:0]        l_ram_wea,
    input  logic [N_LAYERS*ADDR_W-1:0] l_ram_addr_r,
    input  logic [N_LAYERS-1:0]        l_ram_en_r,
    input  logic [N_LAYERS*ADDR_W-1:0] l_rom_addr_rw,
    input  logic [N_LAYERS-1:0]        l_rom_en_rw,
    input  logic [N_LAYERS*ROW_W-1:0]  l_rom_addr_row,
    input  logic [N_LAYERS-1:0]        l_rom_en_row,
    input  logic [2:0]                 sel,
    input  logic                       own,
    output mem_req_t                   req
);

    mem_req_t lane [N_LAYERS];

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_lane
        assign lane[k] = '{
            ram_addr_w:   l_ram_addr_w[k*ADDR_W +: ADDR_W],
            ram_data_w:   l_ram_data_w[k*DATA_W +: DATA_W],
            ram_en:       l_ram_en[k],
            ram_wea:      l_ram_wea[k],
            ram_addr_r:   l_ram_addr_r[k*ADDR_W +: ADDR_W],
            ram_en_r:     l_ram_en_r[k],
            rom_addr_rw:  l_rom_addr_rw[k*ADDR_W +: ADDR_W],
            rom_en_rw:    l_rom_en_rw[k],
            rom_addr_row: l_rom_addr_row[k*ROW_W +: ROW_W],
            rom_en_row:   l_rom_en_row[k]
        };
    end

    always_comb begin
        req = '0;
        if (own && (int'(sel) < N_LAYERS))
            req = lane[sel];
    end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences the network layers one at a time, grants the active layer the
// shared memory ports, watches for per-layer timeouts and captures the class.
module layer_scheduler
    import sched_pkg::*;
#(
    parameter int N_LAYERS = 7,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 cur_layer,
    output logic [N_LAYERS-1:0]        layer_start,
    input  logic [N_LAYERS-1:0]        layer_end,
    input  logic [N_LAYERS*ADDR_W-1:0] l_ram_addr_w,
    input  logic [N_LAYERS*DATA_W-1:0] l_ram_data_w,
    input  logic [N_LAYERS-1:0]        l_ram_en,
    input  logic [N_LAYERS-1:0]        l_ram_wea,
    input  logic [N_LAYERS*ADDR_W-1:0] l_ram_addr_r,
    input  logic [N_LAYERS-1:0]        l_ram_en_r,
    input  logic [N_LAYERS*ADDR_W-1:0] l_rom_addr_rw,
    input  logic [N_LAYERS-1:0]        l_rom_en_rw,
    input  logic [N_LAYERS*ROW_W-1:0]  l_rom_addr_row,
    input  logic [N_LAYERS-1:0]        l_rom_en_row,
    output logic [ADDR_W-1:0]          ram_addr_w,
    output logic [DATA_W-1:0]          ram_data_w,
    output logic                       ram_en,
    output logic                       ram_wea,
    output logic [ADDR_W-1:0]          ram_addr_r,
    output logic                       ram_en_r,
    output logic [ADDR_W-1:0]          rom_addr_rw,
    output logic                       rom_en_rw,
    output logic [ROW_W-1:0]           rom_addr_row,
    output logic                       rom_en_row,
    input  logic signed [7:0]          score_a,
    input  logic signed [7:0]          score_b,
    output logic                       class_out,
    output logic                       result_valid
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 2);
    localparam logic [2:0] LAST = 3'(N_LAYERS - 1);

    sched_state_t state, state_nxt;
    logic [2:0]          idx;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [N_LAYERS-1:0] end_q;
    logic                end_rise, tmo_hit, gap_ok, run_ok, own;
    mem_req_t            req;

    assign end_rise = layer_end[idx] & ~end_q[idx];
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    // The end level must be low both live and in its registered copy, so a
    // held end pulse is fully released before the next layer is launched.
    assign gap_ok   = ~layer_end[idx] & ~end_q[idx] & (gap_cnt >= GAP_W'(GAP_CYC));
    assign run_ok   = run & ~abort & ((state == S_IDLE) | (state == S_ERROR));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (run) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (end_rise)     state_nxt = S_GAP;
                else if (tmo_hit) state_nxt = S_ERROR;
            end
            S_GAP:    if (gap_ok) state_nxt = (idx == LAST) ? S_FINISH : S_LAUNCH;
            S_FINISH: state_nxt = S_IDLE;
            S_ERROR:  if (run) state_nxt = S_LAUNCH;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            end_q        <= '0;
            err          <= 1'b0;
            class_out    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            end_q <= layer_end;
            if (abort) begin
                idx <= '0;
                err <= 1'b0;
            end else begin
                if (run_ok) begin
                    idx          <= '0;
                    err          <= 1'b0;
                    result_valid <= 1'b0;
                end
                unique case (state)
                    S_LAUNCH: tmo_cnt <= '0;
                    S_WAIT: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        gap_cnt <= '0;
                        if (!end_rise && tmo_hit) err <= 1'b1;
                    end
                    S_GAP: begin
                        if (gap_cnt < GAP_W'(GAP_CYC)) gap_cnt <= gap_cnt + GAP_W'(1);
                        if (gap_ok && idx != LAST)     idx <= idx + 3'd1;
                    end
                    S_FINISH: begin
                        class_out    <= (score_b > score_a);
                        result_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state == S_LAUNCH) | (state == S_WAIT) | (state == S_GAP) | (state == S_FINISH);
    assign done      = (state == S_FINISH);
    assign own       = (state == S_LAUNCH) | (state == S_WAIT);
    assign cur_layer = idx;

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_start
        assign layer_start[k] = (state == S_LAUNCH) && (idx == 3'(k));
    end

    layer_port_mux #(.N_LAYERS(N_LAYERS)) u_mux (
        .l_ram_addr_w   (l_ram_addr_w),
        .l_ram_data_w   (l_ram_data_w),
        .l_ram_en       (l_ram_en),
        .l_ram_wea      (l_ram_wea),
        .l_ram_addr_r   (l_ram_addr_r),
        .l_ram_en_r     (l_ram_en_r),
        .l_rom_addr_rw  (l_rom_addr_rw),
        .l_rom_en_rw    (l_rom_en_rw),
        .l_rom_addr_row (l_rom_addr_row),
        .l_rom_en_row   (l_rom_en_row),
        .sel            (idx),
        .own            (own),
        .req            (req)
    );

    assign ram_addr_w   = req.ram_addr_w;
    assign ram_data_w   = req.ram_data_w;
    assign ram_en       = req.ram_en;
    assign ram_wea      = req.ram_wea;
    assign ram_addr_r   = req.ram_addr_r;
    assign ram_en_r     = req.ram_en_r;
    assign rom_addr_rw  = req.rom_addr_rw;
    assign rom_en_rw    = req.rom_en_rw;
    assign rom_addr_row = req.rom_addr_row;
    assign rom_en_row   = req.rom_en_row;

endmodule
